// File: rtl/rca_operand_sequencer_if.sv
// Operand/result handshake bundle between an upstream producer, the sequencer and a downstream consumer.
interface rca_operand_sequencer_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_chain;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    // Producer/consumer side
    modport master (
        output in_valid, in_a, in_b, in_cin, in_chain, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    // Sequencer side
    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_chain, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/rca_operand_sequencer.sv
// Sequences operand pairs into an external ripple-carry adder, waits a fixed
// settle interval, captures the result and hands it downstream.
module rca_operand_sequencer #(
    parameter int unsigned WIDTH         = 16,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rca_operand_sequencer_if.slave bus,
    output logic [WIDTH-1:0]      add_x,
    output logic [WIDTH-1:0]      add_y,
    output logic                  add_cin,
    input  logic [WIDTH-1:0]      add_s,
    input  logic                  add_cout,
    output logic                  busy
);

    localparam int unsigned CNT_W = 4;

    // Settle interval must fit the 4-bit down-counter and be at least one edge
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("rca_operand_sequencer: SETTLE_CYCLES must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   add_x_q, add_x_d;
    logic [WIDTH-1:0]   add_y_q, add_y_d;
    logic               add_cin_q, add_cin_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        carry_d     = carry_q;
        add_x_d     = add_x_q;
        add_y_d     = add_y_q;
        add_cin_d   = add_cin_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    add_x_d   = bus.in_a;
                    add_y_d   = bus.in_b;
                    add_cin_d = bus.in_chain ? carry_q : bus.in_cin;
                    count_d   = CNT_W'(SETTLE_CYCLES - 1);
                    state_d   = SETTLE;
                end
            end
            SETTLE: begin
                if (count_q != '0) begin
                    count_d = count_q - CNT_W'(1);
                end else begin
                    sum_d       = add_s;
                    cout_d      = add_cout;
                    carry_d     = add_cout;
                    // Overflow judged against the latched operands, not the live inputs
                    ovf_d       = (add_x_q[WIDTH-1] == add_y_q[WIDTH-1]) &&
                                  (add_s[WIDTH-1] != add_x_q[WIDTH-1]);
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            carry_q     <= 1'b0;
            add_x_q     <= '0;
            add_y_q     <= '0;
            add_cin_q   <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            carry_q     <= carry_d;
            add_x_q     <= add_x_d;
            add_y_q     <= add_y_d;
            add_cin_q   <= add_cin_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign add_x         = add_x_q;
    assign add_y         = add_y_q;
    assign add_cin       = add_cin_q;
    assign busy          = busy_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;
    assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_rca_operand_sequencer.sv
// Directed bench for rca_operand_sequencer with behavioural adders behind two instances (settle 2 and 4).
module tb_rca_operand_sequencer;

    localparam int unsigned W = 16;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_fail;

    rca_operand_sequencer_if #(.WIDTH(W)) bus0 ();
    rca_operand_sequencer_if #(.WIDTH(W)) bus1 ();

    logic [W-1:0] x0, y0, s0, x1, y1, s1;
    logic         ci0, co0, ci1, co1, busy0, busy1;

    // Behavioural stand-ins for the ripple-carry adder
    assign {co0, s0} = 17'(x0) + 17'(y0) + 17'(ci0);
    assign {co1, s1} = 17'(x1) + 17'(y1) + 17'(ci1);

    rca_operand_sequencer #(.WIDTH(W), .SETTLE_CYCLES(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave),
        .add_x(x0), .add_y(y0), .add_cin(ci0), .add_s(s0), .add_cout(co0), .busy(busy0)
    );

    rca_operand_sequencer #(.WIDTH(W), .SETTLE_CYCLES(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave),
        .add_x(x1), .add_y(y1), .add_cin(ci1), .add_s(s1), .add_cout(co1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand pair on dut0 and return just after the accepting edge
    task automatic send0(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic chain);
        bus0.in_a     = a;
        bus0.in_b     = b;
        bus0.in_cin   = cin;
        bus0.in_chain = chain;
        bus0.in_valid = 1'b1;
        tick();
        bus0.in_valid = 1'b0;
        bus0.in_a     = '1;
        bus0.in_b     = '1;
        bus0.in_cin   = ~cin;
    endtask

    // Bounded wait for dut0 result, then check latency and payload
    task automatic wait_result0(input string tag, input logic [W-1:0] e_sum, input logic e_cout,
                                input logic e_ovf, input int e_lat);
        int n;
        n = 0;
        while (!bus0.out_valid && n < 20) begin
            check_eq({tag, "_busy"}, 32'(busy0), 32'd1);
            tick();
            n++;
        end
        check_eq({tag, "_latency"}, 32'(n), 32'(e_lat));
        check_eq({tag, "_sum"},  32'(bus0.out_sum),  32'(e_sum));
        check_eq({tag, "_cout"}, 32'(bus0.out_cout), 32'(e_cout));
        check_eq({tag, "_ovf"},  32'(bus0.out_ovf),  32'(e_ovf));
    endtask

    task automatic ack0(input string tag);
        bus0.out_ready = 1'b1;
        tick();
        bus0.out_ready = 1'b0;
        check_eq({tag, "_valid_drop"}, 32'(bus0.out_valid), 32'd0);
        check_eq({tag, "_ready_back"}, 32'(bus0.in_ready), 32'd1);
    endtask

    initial begin
        int n;
        logic [W-1:0] held_sum;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus0.in_valid = 1'b0; bus0.in_a = '0; bus0.in_b = '0; bus0.in_cin = 1'b0;
        bus0.in_chain = 1'b0; bus0.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.in_cin = 1'b0;
        bus1.in_chain = 1'b0; bus1.out_ready = 1'b0;

        // Reset state
        #12;
        check_eq("rst_valid", 32'(bus0.out_valid), 32'd0);
        check_eq("rst_busy",  32'(busy0),          32'd0);
        check_eq("rst_add_x", 32'(x0),             32'd0);
        check_eq("rst_sum",   32'(bus0.out_sum),   32'd0);
        #10 rst_n = 1'b1;
        tick();
        check_eq("rst_in_ready", 32'(bus0.in_ready), 32'd1);

        // 1: basic add and latency
        send0(16'h0001, 16'h0004, 1'b0, 1'b0);
        check_eq("t1_in_ready_low", 32'(bus0.in_ready), 32'd0);
        wait_result0("t1", 16'h0005, 1'b0, 1'b0, 2);
        ack0("t1");

        // 2: overflow then no overflow
        send0(16'h5FFF, 16'h6D3F, 1'b0, 1'b0);
        wait_result0("t2a", 16'hCD3E, 1'b0, 1'b1, 2);
        ack0("t2a");
        send0(16'h7FEA, 16'h0002, 1'b0, 1'b0);
        wait_result0("t2b", 16'h7FEC, 1'b0, 1'b0, 2);
        ack0("t2b");

        // 3: carry chain across two words
        send0(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_result0("t3a", 16'h0000, 1'b1, 1'b0, 2);
        ack0("t3a");
        send0(16'h0000, 16'h0000, 1'b0, 1'b1);
        wait_result0("t3b", 16'h0001, 1'b0, 1'b0, 2);
        ack0("t3b");

        // 4: backpressure with a second pair waiting
        send0(16'h1234, 16'h1111, 1'b0, 1'b0);
        wait_result0("t4a", 16'h2345, 1'b0, 1'b0, 2);
        held_sum = bus0.out_sum;
        bus0.in_a = 16'h0F0F; bus0.in_b = 16'h00F1; bus0.in_cin = 1'b0;
        bus0.in_chain = 1'b0; bus0.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("t4_sum_stable",  32'(bus0.out_sum),   32'h2345);
            check_eq("t4_valid_held",  32'(bus0.out_valid), 32'd1);
            check_eq("t4_in_ready",    32'(bus0.in_ready),  32'd0);
        end
        bus0.out_ready = 1'b1;
        tick();
        bus0.out_ready = 1'b0;
        check_eq("t4_release_valid", 32'(bus0.out_valid), 32'd0);
        check_eq("t4_release_busy",  32'(busy0),          32'd0);
        check_eq("t4_release_add_x", 32'(x0),             32'(held_sum - held_sum + 16'h1234));
        tick();
        bus0.in_valid = 1'b0;
        check_eq("t4_second_taken", 32'(x0), 32'h0F0F);
        wait_result0("t4b", 16'h1000, 1'b0, 1'b0, 2);
        ack0("t4b");

        // 5: reset mid-SETTLE clears carry and outputs
        send0(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_result0("t5a", 16'h0000, 1'b1, 1'b0, 2);
        ack0("t5a");
        send0(16'h0102, 16'h0304, 1'b0, 1'b0);
        check_eq("t5_pre_busy", 32'(busy0), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t5_rst_valid", 32'(bus0.out_valid), 32'd0);
        check_eq("t5_rst_busy",  32'(busy0),          32'd0);
        check_eq("t5_rst_add_x", 32'(x0),             32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        send0(16'h0000, 16'h0000, 1'b1, 1'b1);
        check_eq("t5_chain_cin", 32'(ci0), 32'd0);
        wait_result0("t5b", 16'h0000, 1'b0, 1'b0, 2);
        ack0("t5b");

        // 6: four-edge settle, operands held steady throughout
        bus1.in_a = 16'h08E8; bus1.in_b = 16'h0618; bus1.in_cin = 1'b0;
        bus1.in_chain = 1'b0; bus1.in_valid = 1'b1;
        tick();
        bus1.in_valid = 1'b0; bus1.in_a = 16'hAAAA; bus1.in_b = 16'h5555;
        n = 0;
        while (!bus1.out_valid && n < 20) begin
            check_eq("t6_x_stable", 32'(x1), 32'h08E8);
            check_eq("t6_y_stable", 32'(y1), 32'h0618);
            tick();
            n++;
        end
        check_eq("t6_latency", 32'(n), 32'd4);
        check_eq("t6_sum",  32'(bus1.out_sum),  32'h0F00);
        check_eq("t6_cout", 32'(bus1.out_cout), 32'd0);
        bus1.out_ready = 1'b1;
        tick();
        bus1.out_ready = 1'b0;
        check_eq("t6_valid_drop", 32'(bus1.out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
